// File: rtl/imem_program_loader.sv
// ----------------------------------------------------------------------------
// imem_program_loader
//
// Packs instruction fields (opcode, rd, rs1, rs2, imm) into 32-bit instruction
// words and writes them one after another into instruction memory. The boot
// path or a testbench uses it to load a program into the single-cycle core
// before execution starts.
//
// Fields that an instruction class does not use are forced to zero, so every
// word written has a canonical encoding. Unknown opcodes end the session with
// an error, and no word is written for them.
//
// Word layout: {opcode[31:27], rd[26:22], rs1[21:17], rs2[16:12], imm[11:0]}
//
// Parameters
//   ADDR_W     IMem word-address width; capacity is 2^ADDR_W words
//   BASE_ADDR  first word address written after start
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse, begins a session at BASE_ADDR (IDLE only)
//   in_valid    instruction fields valid
//   in_ready    loader accepts fields this cycle (high in LOAD)
//   in_last     marks the final instruction (sampled with in_valid)
//   in_opcode   opcode, 1..20 legal
//   in_rd       destination register
//   in_rs1      source register 1
//   in_rs2      source register 2
//   in_imm      immediate
//   imem_we     IMem write strobe, one cycle per word
//   imem_addr   IMem word address
//   imem_wdata  encoded instruction
//   busy        session in progress (LOAD or DRAIN)
//   done        sticky, session completed normally
//   err         sticky, illegal opcode or capacity overflow
//   word_count  words written in this session
//
// State table
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no session; waits for start, in_ready low
//   S_LOAD  | accepting fields; each legal transfer writes one word a
//           | cycle later
//   S_DRAIN | final word is on the write port; closes session with done
//           | (last seen) or err (memory filled without last)
// ----------------------------------------------------------------------------
module imem_program_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W+1)'(1);
    // word_count value at which the next legal word takes the last free slot
    localparam logic [ADDR_W:0]   LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wdata;
    logic                r_we;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W:0]     r_word_count;
    logic                r_last_seen;

    logic                w_xfer;
    logic                w_legal;
    logic                w_write;
    logic                w_at_last_slot;
    logic                w_start_sess;
    logic [31:0]         w_encoded;

    // Canonical encoding: zero the fields the instruction class ignores.
    function automatic logic [31:0] f_encode(
        input logic [4:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        logic [4:0]  v_rd;
        logic [4:0]  v_rs1;
        logic [4:0]  v_rs2;
        logic [11:0] v_imm;
        v_rd  = rd;
        v_rs1 = rs1;
        v_rs2 = rs2;
        v_imm = imm;
        case (op)
            5'd1, 5'd3, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12: begin
                v_imm = '0;
            end
            5'd2, 5'd5, 5'd7, 5'd9, 5'd11, 5'd13, 5'd15, 5'd20: begin
                v_rs2 = '0;
            end
            5'd14, 5'd19: begin
                v_rs1 = '0;
                v_rs2 = '0;
            end
            5'd16, 5'd17, 5'd18: begin
                v_rd = '0;
            end
            default: begin
            end
        endcase
        return {op, v_rd, v_rs1, v_rs2, v_imm};
    endfunction

    assign w_xfer         = in_valid && (r_state == S_LOAD);
    assign w_legal        = (in_opcode >= 5'd1) && (in_opcode <= 5'd20);
    assign w_write        = w_xfer && w_legal;
    assign w_at_last_slot = (r_word_count == LAST_SLOT);
    assign w_start_sess   = start && (r_state == S_IDLE);
    assign w_encoded      = f_encode(in_opcode, in_rd, in_rs1, in_rs2, in_imm);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer) begin
                    if (!w_legal) begin
                        w_state_nxt = S_IDLE;
                    end else if (in_last || w_at_last_slot) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: write port, address/count tracking, sticky status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr   <= BASE;
            r_wr_addr    <= BASE;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
            r_last_seen  <= 1'b0;
        end else begin
            r_we <= w_write;

            if (w_start_sess) begin
                r_cur_addr   <= BASE;
                r_done       <= 1'b0;
                r_err        <= 1'b0;
                r_word_count <= '0;
                r_last_seen  <= 1'b0;
            end

            if (w_write) begin
                r_wr_addr    <= r_cur_addr;
                r_wdata      <= w_encoded;
                // address wraps naturally modulo 2^ADDR_W
                r_cur_addr   <= r_cur_addr + ADDR_ONE;
                r_word_count <= r_word_count + WC_ONE;
                r_last_seen  <= in_last;
            end

            if (w_xfer && !w_legal) begin
                r_err <= 1'b1;
            end

            // Reaching DRAIN without in_last means memory filled up first.
            if (r_state == S_DRAIN) begin
                if (r_last_seen) begin
                    r_done <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_wr_addr;
    assign imem_wdata = r_wdata;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_word_count;

endmodule
